// File: rtl/simple_axi_slave_mem.sv
// Single-outstanding, single-beat AXI4 slave backed by a byte-strobed register array.
// Each B/R response is delayed by LATENCY idle cycles through a down-counter.
module simple_axi_slave_mem #(
    parameter int WIDTH       = 64,
    parameter int DEPTH_BYTES = 128,
    parameter int LATENCY     = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               s_axi_awvalid,
    output logic               s_axi_awready,
    input  logic [31:0]        s_axi_awaddr,
    input  logic [2:0]         s_axi_awsize,
    input  logic               s_axi_wvalid,
    output logic               s_axi_wready,
    input  logic [WIDTH-1:0]   s_axi_wdata,
    input  logic [WIDTH/8-1:0] s_axi_wstrb,
    input  logic               s_axi_wlast,
    output logic               s_axi_bvalid,
    input  logic               s_axi_bready,
    output logic [1:0]         s_axi_bresp,
    input  logic               s_axi_arvalid,
    output logic               s_axi_arready,
    input  logic [31:0]        s_axi_araddr,
    input  logic [2:0]         s_axi_arsize,
    output logic               s_axi_rvalid,
    input  logic               s_axi_rready,
    output logic [WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]         s_axi_rresp,
    output logic               s_axi_rlast
);

    localparam int NLANES  = WIDTH / 8;
    localparam int LSB     = $clog2(NLANES);
    localparam int NWORDS  = DEPTH_BYTES / NLANES;
    localparam int IW      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_BYTES);
    localparam logic [7:0]  LAT_L   = 8'(LATENCY);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // state   | meaning
    // IDLE    | waiting for a request; AW wins over AR
    // AW_ACK  | awready pulse, address captured
    // W_WAIT  | waiting for wvalid
    // W_ACK   | wready pulse, memory updated on OKAY
    // B_LAT   | latency countdown before write response
    // B_RESP  | bvalid held until bready
    // AR_ACK  | arready pulse, read word registered
    // R_LAT   | latency countdown before read response
    // R_RESP  | rvalid/rlast held until rready
    typedef enum logic [3:0] {
        IDLE, AW_ACK, W_WAIT, W_ACK, B_LAT, B_RESP, AR_ACK, R_LAT, R_RESP
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [31:0]      r_addr;
    logic [2:0]       r_size;
    logic             r_awready;
    logic             r_wready;
    logic             r_bvalid;
    logic [1:0]       r_bresp;
    logic             r_arready;
    logic             r_rvalid;
    logic [WIDTH-1:0] r_rdata;
    logic [1:0]       r_rresp;
    logic             r_rlast;

    // Not reset; contents are zero at configuration/power-up on the target fabric.
    logic [WIDTH-1:0] r_mem [NWORDS];

    function automatic logic [1:0] f_addr_resp(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] mask;
        mask = (32'd1 << size) - 32'd1;
        if (addr >= DEPTH_L)
            return RESP_DECERR;
        if ((size > 3'd3) || ((addr & mask) != 32'd0))
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    logic [1:0]    w_aw_resp;
    logic [1:0]    w_w_resp;
    logic [1:0]    w_ar_resp;
    logic [IW-1:0] w_w_idx;
    logic [IW-1:0] w_ar_idx;
    logic          w_mem_we;

    assign w_aw_resp = f_addr_resp(r_addr, r_size);
    assign w_w_resp  = (w_aw_resp != RESP_OKAY) ? w_aw_resp :
                       (!s_axi_wlast ? RESP_SLVERR : RESP_OKAY);
    assign w_ar_resp = f_addr_resp(s_axi_araddr, s_axi_arsize);
    assign w_w_idx   = IW'(r_addr >> LSB);
    assign w_ar_idx  = IW'(s_axi_araddr >> LSB);
    assign w_mem_we  = (r_state == W_ACK) && (w_w_resp == RESP_OKAY);

    // A beat accepted in W_ACK commits even if reset lands on the same edge.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < NLANES; k++) begin
                if (s_axi_wstrb[k])
                    r_mem[w_w_idx][k*8 +: 8] <= s_axi_wdata[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_addr    <= 32'd0;
            r_size    <= 3'd0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rlast   <= 1'b0;
        end else begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (s_axi_awvalid) begin
                        r_state   <= AW_ACK;
                        r_awready <= 1'b1;
                    end else if (s_axi_arvalid) begin
                        r_state   <= AR_ACK;
                        r_arready <= 1'b1;
                    end
                end
                AW_ACK: begin
                    r_addr  <= s_axi_awaddr;
                    r_size  <= s_axi_awsize;
                    r_state <= W_WAIT;
                end
                W_WAIT: begin
                    if (s_axi_wvalid) begin
                        r_state  <= W_ACK;
                        r_wready <= 1'b1;
                    end
                end
                W_ACK: begin
                    r_bresp <= w_w_resp;
                    if (LATENCY > 0) begin
                        r_state <= B_LAT;
                        r_cnt   <= LAT_L;
                    end else begin
                        r_state  <= B_RESP;
                        r_bvalid <= 1'b1;
                    end
                end
                B_LAT: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state  <= B_RESP;
                        r_bvalid <= 1'b1;
                    end
                end
                B_RESP: begin
                    if (s_axi_bready) begin
                        r_state  <= IDLE;
                        r_bvalid <= 1'b0;
                    end
                end
                AR_ACK: begin
                    r_addr  <= s_axi_araddr;
                    r_size  <= s_axi_arsize;
                    r_rresp <= w_ar_resp;
                    r_rdata <= (w_ar_resp == RESP_OKAY) ? r_mem[w_ar_idx] : '0;
                    if (LATENCY > 0) begin
                        r_state <= R_LAT;
                        r_cnt   <= LAT_L;
                    end else begin
                        r_state  <= R_RESP;
                        r_rvalid <= 1'b1;
                        r_rlast  <= 1'b1;
                    end
                end
                R_LAT: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state  <= R_RESP;
                        r_rvalid <= 1'b1;
                        r_rlast  <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        r_state  <= IDLE;
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;

endmodule

// File: tb/tb_simple_axi_slave_mem.sv
// Directed bench for simple_axi_slave_mem: a LATENCY=0 and a LATENCY=5 instance share
// one stimulus set; sel gates the valid/ready inputs and picks whose outputs are observed.
module tb_simple_axi_slave_mem;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [31:0] awaddr, araddr;
    logic [2:0]  awsize, arsize;
    logic [63:0] wdata;
    logic [7:0]  wstrb;

    logic        awready0, wready0, bvalid0, arready0, rvalid0, rlast0;
    logic [1:0]  bresp0, rresp0;
    logic [63:0] rdata0;
    logic        awready5, wready5, bvalid5, arready5, rvalid5, rlast5;
    logic [1:0]  bresp5, rresp5;
    logic [63:0] rdata5;

    wire         awready = sel ? awready5 : awready0;
    wire         wready  = sel ? wready5  : wready0;
    wire         bvalid  = sel ? bvalid5  : bvalid0;
    wire  [1:0]  bresp   = sel ? bresp5   : bresp0;
    wire         arready = sel ? arready5 : arready0;
    wire         rvalid  = sel ? rvalid5  : rvalid0;
    wire  [63:0] rdata   = sel ? rdata5   : rdata0;
    wire  [1:0]  rresp   = sel ? rresp5   : rresp0;
    wire         rlast   = sel ? rlast5   : rlast0;

    simple_axi_slave_mem #(.WIDTH(64), .DEPTH_BYTES(128), .LATENCY(0)) u_dut0 (
        .clk(clk), .rstn(rstn),
        .s_axi_awvalid(awvalid & ~sel), .s_axi_awready(awready0),
        .s_axi_awaddr(awaddr), .s_axi_awsize(awsize),
        .s_axi_wvalid(wvalid & ~sel), .s_axi_wready(wready0),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid0), .s_axi_bready(bready & ~sel), .s_axi_bresp(bresp0),
        .s_axi_arvalid(arvalid & ~sel), .s_axi_arready(arready0),
        .s_axi_araddr(araddr), .s_axi_arsize(arsize),
        .s_axi_rvalid(rvalid0), .s_axi_rready(rready & ~sel),
        .s_axi_rdata(rdata0), .s_axi_rresp(rresp0), .s_axi_rlast(rlast0)
    );

    simple_axi_slave_mem #(.WIDTH(64), .DEPTH_BYTES(128), .LATENCY(5)) u_dut5 (
        .clk(clk), .rstn(rstn),
        .s_axi_awvalid(awvalid & sel), .s_axi_awready(awready5),
        .s_axi_awaddr(awaddr), .s_axi_awsize(awsize),
        .s_axi_wvalid(wvalid & sel), .s_axi_wready(wready5),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid5), .s_axi_bready(bready & sel), .s_axi_bresp(bresp5),
        .s_axi_arvalid(arvalid & sel), .s_axi_arready(arready5),
        .s_axi_araddr(araddr), .s_axi_arsize(arsize),
        .s_axi_rvalid(rvalid5), .s_axi_rready(rready & sel),
        .s_axi_rdata(rdata5), .s_axi_rresp(rresp5), .s_axi_rlast(rlast5)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wlast = 0;
    endtask

    // Master holds every valid from the start; bready goes high after 'hold' cycles of bvalid.
    task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d,
                            input logic [7:0] st, input logic lst, input int hold,
                            output logic [1:0] resp, output int t_aw, output int t_w,
                            output int t_b, output int n_aw, output int n_w,
                            output int bad, output bit done);
        int t, held;
        bit s_aw, s_w, s_b;
        @(negedge clk);
        awaddr = a; awsize = sz; awvalid = 1;
        wdata = d; wstrb = st; wlast = lst; wvalid = 1;
        bready = (hold == 0);
        t = 0; held = 0; done = 0; bad = 0;
        t_aw = -1; t_w = -1; t_b = -1; n_aw = 0; n_w = 0; resp = 2'b00;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
            s_aw = awready; s_w = wready; s_b = bvalid;
            if (s_aw) begin n_aw++; if (t_aw < 0) t_aw = t; end
            if (s_w)  begin n_w++;  if (t_w < 0)  t_w = t;  end
            if (t_b >= 0 && (!s_b || bresp !== resp)) bad++;
            if (s_b && t_b < 0) begin t_b = t; resp = bresp; end
            if (s_b && bready) done = 1;
            else if (s_b) held++;
            @(posedge clk); #1;
            if (s_aw) awvalid = 0;
            if (s_w) wvalid = 0;
            if (done) bready = 0;
            else if (s_b && held >= hold) bready = 1;
        end
        clear_inputs();
        @(negedge clk);
        if (bvalid || awready || wready) bad++;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] sz, input int hold,
                           output logic [63:0] d, output logic [1:0] resp, output logic lst,
                           output int t_ar, output int t_r, output int n_ar,
                           output int bad, output bit done);
        int t, held;
        bit s_ar, s_r;
        @(negedge clk);
        araddr = a; arsize = sz; arvalid = 1;
        rready = (hold == 0);
        t = 0; held = 0; done = 0; bad = 0;
        t_ar = -1; t_r = -1; n_ar = 0; d = '0; resp = 2'b00; lst = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
            s_ar = arready; s_r = rvalid;
            if (s_ar) begin n_ar++; if (t_ar < 0) t_ar = t; end
            if (t_r >= 0 && (!s_r || rdata !== d || rresp !== resp || rlast !== lst)) bad++;
            if (s_r && t_r < 0) begin t_r = t; d = rdata; resp = rresp; lst = rlast; end
            if (s_r && rready) done = 1;
            else if (s_r) held++;
            @(posedge clk); #1;
            if (s_ar) arvalid = 0;
            if (done) rready = 0;
            else if (s_r && held >= hold) rready = 1;
        end
        clear_inputs();
        @(negedge clk);
        if (rvalid || arready) bad++;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [1:0]  resp;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs[$];

    logic [1:0]  r_resp;
    logic [63:0] r_data;
    logic        r_last;
    int          ta, tw, tb, na, nw, nbad;
    bit          ok;

    function automatic logic [9:0] ctrl_bits(input bit s);
        if (s)
            return {awready5, wready5, bvalid5, bresp5, arready5, rvalid5, rresp5, rlast5};
        return {awready0, wready0, bvalid0, bresp0, arready0, rvalid0, rresp0, rlast0};
    endfunction

    initial begin
        // wr addr size data strb last resp rdata
        vecs.push_back('{1'b1, 32'h08, 3'd3, 64'h11DD11DD_22EE22EE, 8'hFF, 1'b1, 2'b00, 64'h0});
        vecs.push_back('{1'b0, 32'h08, 3'd3, 64'h0, 8'h00, 1'b0, 2'b00, 64'h11DD11DD_22EE22EE});
        vecs.push_back('{1'b1, 32'h40, 3'd0, 64'h00000000_000000FF, 8'h01, 1'b1, 2'b00, 64'h0});
        vecs.push_back('{1'b1, 32'h41, 3'd0, 64'h00000000_0000EE00, 8'h02, 1'b1, 2'b00, 64'h0});
        vecs.push_back('{1'b0, 32'h40, 3'd1, 64'h0, 8'h00, 1'b0, 2'b00, 64'h00000000_0000EEFF});
        vecs.push_back('{1'b1, 32'h00, 3'd3, 64'hA5A5A5A5_A5A5A5A5, 8'hFF, 1'b1, 2'b00, 64'h0});
        vecs.push_back('{1'b1, 32'h02, 3'd2, 64'hDEADBEEF_DEADBEEF, 8'hFF, 1'b1, 2'b10, 64'h0});
        vecs.push_back('{1'b1, 32'h80, 3'd3, 64'h5A5A5A5A_5A5A5A5A, 8'hFF, 1'b1, 2'b11, 64'h0});
        vecs.push_back('{1'b0, 32'h00, 3'd3, 64'h0, 8'h00, 1'b0, 2'b00, 64'hA5A5A5A5_A5A5A5A5});
        vecs.push_back('{1'b0, 32'h80, 3'd3, 64'h0, 8'h00, 1'b0, 2'b11, 64'h0});
        vecs.push_back('{1'b0, 32'h81, 3'd3, 64'h0, 8'h00, 1'b0, 2'b11, 64'h0});
        vecs.push_back('{1'b1, 32'h10, 3'd3, 64'h01234567_89ABCDEF, 8'hFF, 1'b1, 2'b00, 64'h0});
        vecs.push_back('{1'b1, 32'h10, 3'd3, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1'b0, 2'b10, 64'h0});
        vecs.push_back('{1'b0, 32'h10, 3'd3, 64'h0, 8'h00, 1'b0, 2'b00, 64'h01234567_89ABCDEF});
        vecs.push_back('{1'b0, 32'h20, 3'd4, 64'h0, 8'h00, 1'b0, 2'b10, 64'h0});
        vecs.push_back('{1'b0, 32'h0C, 3'd3, 64'h0, 8'h00, 1'b0, 2'b10, 64'h0});
        vecs.push_back('{1'b0, 32'h0C, 3'd2, 64'h0, 8'h00, 1'b0, 2'b00, 64'h11DD11DD_22EE22EE});
        vecs.push_back('{1'b0, 32'h41, 3'd1, 64'h0, 8'h00, 1'b0, 2'b10, 64'h0});
        vecs.push_back('{1'b1, 32'h78, 3'd3, 64'h11111111_11111111, 8'hFF, 1'b1, 2'b00, 64'h0});
        vecs.push_back('{1'b1, 32'h7F, 3'd0, 64'h99000000_00000000, 8'h80, 1'b1, 2'b00, 64'h0});
        vecs.push_back('{1'b0, 32'h78, 3'd3, 64'h0, 8'h00, 1'b0, 2'b00, 64'h99111111_11111111});
        vecs.push_back('{1'b1, 32'h7C, 3'd2, 64'hCCCCCCCC_00000000, 8'hF0, 1'b1, 2'b00, 64'h0});
        vecs.push_back('{1'b0, 32'h7C, 3'd2, 64'h0, 8'h00, 1'b0, 2'b00, 64'hCCCCCCCC_11111111});
        vecs.push_back('{1'b1, 32'h08, 3'd3, 64'h0, 8'h00, 1'b1, 2'b00, 64'h0});
        vecs.push_back('{1'b0, 32'h08, 3'd3, 64'h0, 8'h00, 1'b0, 2'b00, 64'h11DD11DD_22EE22EE});

        awaddr = 0; awsize = 0; araddr = 0; arsize = 0; wdata = 0; wstrb = 0;
        clear_inputs();
        rstn = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl_lat0", 64'(ctrl_bits(1'b0)), 64'h0);
        chk("reset_rdata_lat0", rdata0, 64'h0);
        chk("reset_ctrl_lat5", 64'(ctrl_bits(1'b1)), 64'h0);
        chk("reset_rdata_lat5", rdata5, 64'h0);
        rstn = 1;
        nbad = 0;
        repeat (4) begin
            @(negedge clk);
            if (ctrl_bits(1'b0) != 10'h0 || ctrl_bits(1'b1) != 10'h0) nbad++;
        end
        chk("idle_no_ready", nbad, 0);

        sel = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].strb, vecs[i].last, 0,
                         r_resp, ta, tw, tb, na, nw, nbad, ok);
                chk($sformatf("v%0d_done", i), 64'(ok), 64'h1);
                chk($sformatf("v%0d_bresp", i), r_resp, vecs[i].resp);
                chk($sformatf("v%0d_awready_cyc", i), ta, 1);
                chk($sformatf("v%0d_wready_cyc", i), tw, 3);
                chk($sformatf("v%0d_bvalid_cyc", i), tb, 4);
                chk($sformatf("v%0d_ready_pulses", i), {na[31:0], nw[31:0]}, {32'd1, 32'd1});
                chk($sformatf("v%0d_protocol", i), nbad, 0);
            end else begin
                do_read(vecs[i].addr, vecs[i].size, 0, r_data, r_resp, r_last, ta, tb, na, nbad, ok);
                chk($sformatf("v%0d_done", i), 64'(ok), 64'h1);
                chk($sformatf("v%0d_rresp", i), r_resp, vecs[i].resp);
                chk($sformatf("v%0d_rdata", i), r_data, vecs[i].rdata);
                chk($sformatf("v%0d_rlast", i), 64'(r_last), 64'h1);
                chk($sformatf("v%0d_arready_cyc", i), ta, 1);
                chk($sformatf("v%0d_rvalid_cyc", i), tb, 2);
                chk($sformatf("v%0d_ready_pulses", i), na, 1);
                chk($sformatf("v%0d_protocol", i), nbad, 0);
            end
        end

        // LATENCY=5 instance, with bready/rready held off for 4 cycles
        @(negedge clk);
        sel = 1;
        do_write(32'h08, 3'd3, 64'h0BADF00D_CAFEBABE, 8'hFF, 1'b1, 4, r_resp, ta, tw, tb, na, nw, nbad, ok);
        chk("lat5_w_done", 64'(ok), 64'h1);
        chk("lat5_bresp", r_resp, 2'b00);
        chk("lat5_awready_cyc", ta, 1);
        chk("lat5_wready_cyc", tw, 3);
        chk("lat5_bvalid_cyc", tb, 9);
        chk("lat5_w_pulses", {na[31:0], nw[31:0]}, {32'd1, 32'd1});
        chk("lat5_b_stable", nbad, 0);
        do_read(32'h08, 3'd3, 4, r_data, r_resp, r_last, ta, tb, na, nbad, ok);
        chk("lat5_r_done", 64'(ok), 64'h1);
        chk("lat5_rresp", r_resp, 2'b00);
        chk("lat5_rdata", r_data, 64'h0BADF00D_CAFEBABE);
        chk("lat5_arready_cyc", ta, 1);
        chk("lat5_rvalid_cyc", tb, 7);
        chk("lat5_r_stable", nbad, 0);
        do_read(32'h80, 3'd3, 0, r_data, r_resp, r_last, ta, tb, na, nbad, ok);
        chk("lat5_decerr_rresp", r_resp, 2'b11);
        chk("lat5_decerr_rdata", r_data, 64'h0);
        chk("lat5_decerr_rvalid_cyc", tb, 7);
        @(negedge clk);
        sel = 0;

        // AW and AR in the same cycle: write first, then read sees the new word
        begin
            int t, t_b, t_ar, t_r, n_ar;
            bit s_b, s_ar, s_r, done;
            @(negedge clk);
            awaddr = 32'h30; awsize = 3'd3; wdata = 64'h3030CAFE_F00D3030; wstrb = 8'hFF; wlast = 1;
            awvalid = 1; wvalid = 1; bready = 1;
            araddr = 32'h30; arsize = 3'd3; arvalid = 1; rready = 1;
            t = 0; t_b = -1; t_ar = -1; t_r = -1; n_ar = 0; done = 0; r_data = '0; r_resp = '0;
            while (!done && t < 100) begin
                @(negedge clk);
                t++;
                s_b = bvalid; s_ar = arready; s_r = rvalid;
                if (awready) awvalid = 0;
                if (wready) wvalid = 0;
                if (s_ar) begin n_ar++; if (t_ar < 0) t_ar = t; end
                if (s_b && t_b < 0) t_b = t;
                if (s_r) begin t_r = t; r_data = rdata; r_resp = rresp; done = 1; end
                @(posedge clk); #1;
                if (s_b) bready = 0;
                if (s_ar) arvalid = 0;
            end
            clear_inputs();
            chk("both_bvalid_cyc", t_b, 4);
            chk("both_arready_cyc", t_ar, 6);
            chk("both_rvalid_cyc", t_r, 7);
            chk("both_arready_pulses", n_ar, 1);
            chk("both_rresp", r_resp, 2'b00);
            chk("both_rdata", r_data, 64'h3030CAFE_F00D3030);
        end

        // Reset while waiting for write data
        do_write(32'h50, 3'd3, 64'h50505050_50505050, 8'hFF, 1'b1, 0, r_resp, ta, tw, tb, na, nw, nbad, ok);
        chk("rst_pre_bresp", r_resp, 2'b00);
        @(negedge clk);
        awaddr = 32'h50; awsize = 3'd3; wdata = 64'hDEDEDEDE_DEDEDEDE; wstrb = 8'hFF; wlast = 1;
        awvalid = 1; wvalid = 0; bready = 1;
        @(negedge clk);
        chk("rst_awready", 64'(awready), 64'h1);
        @(posedge clk); #1;
        awvalid = 0;
        rstn = 0;
        wvalid = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ctrl", 64'(ctrl_bits(1'b0)), 64'h0);
        chk("rst_mid_rdata", rdata0, 64'h0);
        rstn = 1;
        clear_inputs();
        nbad = 0;
        repeat (3) begin
            @(negedge clk);
            if (ctrl_bits(1'b0) != 10'h0) nbad++;
        end
        chk("rst_post_idle", nbad, 0);
        do_read(32'h50, 3'd3, 0, r_data, r_resp, r_last, ta, tb, na, nbad, ok);
        chk("rst_word_unchanged", r_data, 64'h50505050_50505050);
        do_write(32'h50, 3'd3, 64'h77665544_33221100, 8'hFF, 1'b1, 0, r_resp, ta, tw, tb, na, nw, nbad, ok);
        chk("rst_after_bresp", r_resp, 2'b00);
        chk("rst_after_timing", {ta[15:0], tw[15:0], tb[15:0]}, {16'd1, 16'd3, 16'd4});
        do_read(32'h50, 3'd3, 0, r_data, r_resp, r_last, ta, tb, na, nbad, ok);
        chk("rst_after_rdata", r_data, 64'h77665544_33221100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
